// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : muldiv_sequencer                                              |
// | Purpose  : Multi-cycle RV32M multiply/divide controller that borrows the |
// |            execute-stage ALU for shift-add multiply and restoring divide |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [6:0]      alu_funct7,
  output logic [2:0]      alu_funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      alu_flags
);

  localparam int              CW       = $clog2(ITER);
  localparam logic [2:0]      ST_IDLE  = 3'd0;
  localparam logic [2:0]      ST_CALC  = 3'd1;
  localparam logic [2:0]      ST_FIX1  = 3'd2;
  localparam logic [2:0]      ST_FIX2  = 3'd3;
  localparam logic [2:0]      ST_DONE  = 3'd4;
  localparam logic [6:0]      ALU_ADD  = 7'b0000000;
  localparam logic [6:0]      ALU_SUB  = 7'b0100000;
  localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = '0;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // hi holds the upper product / running remainder, lo the lower product /
  // quotient; opd is the addend (|a|) for multiply or the divisor (|b|).
  logic [2:0]      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            lo_zero_q, lo_zero_d;
  logic [XLEN-1:0] opd_q, opd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            a_signed, b_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_by_zero, div_ovf, special;
  logic            is_div, neg, sel_lo, alu_c;
  logic [XLEN:0]   r_ext;
  logic            unused_flags;

  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign alu_funct3 = 3'b000;
  assign accept     = in_valid && in_ready;

  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign abs_a    = (a_signed && op_a[XLEN-1]) ? (ZERO - op_a) : op_a;
  assign abs_b    = (b_signed && op_b[XLEN-1]) ? (ZERO - op_b) : op_b;

  // Divide corner cases resolve immediately without iterating.
  assign div_by_zero = funct3[2] && (op_b == ZERO);
  assign div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (op_a == INT_MIN) && (op_b == ALL_ONES);
  assign special     = div_by_zero || div_ovf;

  assign is_div       = funct3_q[2];
  assign neg          = sa_q ^ sb_q;
  assign sel_lo       = (funct3_q == 3'b000) || (funct3_q == 3'b100) || (funct3_q == 3'b101);
  assign alu_c        = alu_flags[2];
  assign r_ext        = {hi_q, lo_q[XLEN-1]};
  assign unused_flags = ^{alu_flags[3], alu_flags[1:0]};

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      funct3_q  <= 3'b000;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      lo_zero_q <= 1'b0;
      opd_q     <= ZERO;
      hi_q      <= ZERO;
      lo_q      <= ZERO;
      cnt_q     <= '0;
      result_q  <= ZERO;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      lo_zero_q <= lo_zero_d;
      opd_q     <= opd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // Sequencing: load, 32 iterations, two sign-fix steps, then hold result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX1;
      ST_FIX1: state_d = ST_FIX2;
      ST_FIX2: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive and datapath updates for each state.
  always_comb begin
    alu_a      = ZERO;
    alu_b      = ZERO;
    alu_funct7 = ALU_ADD;
    funct3_d   = funct3_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    lo_zero_d  = lo_zero_q;
    opd_d      = opd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d  = funct3;
          sa_d      = a_signed && op_a[XLEN-1];
          sb_d      = b_signed && op_b[XLEN-1];
          lo_zero_d = 1'b0;
          hi_d      = ZERO;
          cnt_d     = '0;
          lo_d      = funct3[2] ? abs_a : abs_b;
          opd_d     = funct3[2] ? abs_b : abs_a;
          if (div_by_zero) result_d = funct3[1] ? op_a : ALL_ONES;
          else if (div_ovf) result_d = funct3[1] ? ZERO : INT_MIN;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_ONE;
        if (is_div) begin
          // Restoring step: trial-subtract divisor from shifted remainder.
          alu_funct7 = ALU_SUB;
          alu_a      = r_ext[XLEN-1:0];
          alu_b      = opd_q;
          if (r_ext[XLEN] || alu_c) begin
            hi_d = alu_result;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = r_ext[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          // Shift-add step: conditionally accumulate, then shift right.
          alu_a = hi_q;
          alu_b = opd_q;
          if (lo_q[0]) {hi_d, lo_d} = {alu_c, alu_result, lo_q[XLEN-1:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
        end
      end
      ST_FIX1: begin
        alu_funct7 = ALU_SUB;
        alu_a      = ZERO;
        alu_b      = lo_q;
        lo_zero_d  = (lo_q == ZERO);
        if (neg) lo_d = alu_result;
      end
      ST_FIX2: begin
        // A 64-bit negate only borrows into hi when the low word was zero.
        alu_funct7 = ALU_SUB;
        alu_a      = ZERO;
        alu_b      = hi_q;
        if (is_div) begin
          if (sa_q) hi_d = alu_result;
        end else if (neg) begin
          hi_d = lo_zero_q ? alu_result : ~hi_q;
        end
        result_d = sel_lo ? lo_d : hi_d;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_muldiv_sequencer                                           |
// | Purpose  : Scoreboard bench for muldiv_sequencer with a behavioural ALU  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [6:0]  alu_funct7;
  logic [2:0]  alu_funct3;
  logic [3:0]  alu_flags;
  logic [32:0] alu_sum;
  logic        alu_v;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] exp_v;
  string       exp_n;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  // Behavioural execute-stage ALU: add or subtract with {V,C,N,Z}.
  always_comb begin
    if (alu_funct7 == 7'b0100000) begin
      alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      alu_v   = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
    end else begin
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      alu_v   = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
    end
    alu_result = alu_sum[31:0];
    alu_flags  = {alu_v, alu_sum[32], alu_sum[31], (alu_sum[31:0] == 32'd0)};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Monitor: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got 0x%h expected none", result);
      end else begin
        exp_v = exp_q.pop_front();
        exp_n = name_q.pop_front();
        if (result !== exp_v) begin
          errors++;
          $display("FAIL %s: got 0x%h expected 0x%h", exp_n, result, exp_v);
        end
      end
    end
  end

  // Issue one op; returns #1 after the accepting edge.
  task automatic start_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input bit expect_out);
    chk({"in_ready_", nm}, {31'd0, in_ready}, 32'd1);
    if (expect_out) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid rises.
  task automatic wait_valid(input string nm, input int lat);
    int n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({"latency_", nm}, n, lat);
  endtask

  task automatic finish_op(input string nm);
    @(posedge clk); #1;
    chk({"pulse_", nm}, {31'd0, out_valid}, 32'd0);
    chk({"idle_", nm}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat);
    start_op(nm, f3, a, b, e, 1'b1);
    wait_valid(nm, lat);
    finish_op(nm);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;

    // Multiply family
    run_op("mul_7x6",        3'b000, 32'd7,        32'd6,        32'h0000002A, 35);
    run_op("mulh_m2x3",      3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 35);
    run_op("mulhu_max",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
    run_op("mulhsu_m1x2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 35);
    run_op("mul_min_x_m1",   3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35);
    run_op("mulh_min_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35);
    run_op("mulh_lo_zero",   3'b001, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 35);
    // Divide family
    run_op("div_m7_2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
    run_op("rem_m7_2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
    run_op("divu_100_7",     3'b101, 32'd100,      32'd7,        32'd14,       35);
    run_op("remu_100_7",     3'b111, 32'd100,      32'd7,        32'd2,        35);
    run_op("div_7_m2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35);
    run_op("rem_7_m2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        35);
    run_op("remu_big",       3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 35);
    // Special cases
    run_op("divu_by_zero",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by_zero",    3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_overflow",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_overflow",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure: result held while out_ready is low, then back-to-back op
    out_ready = 1'b0;
    start_op("bp_mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    wait_valid("bp_mulhu", 35);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_result_stable", result, 32'hFFFFFFFE);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_op("b2b_divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 35);

    // Reset in the middle of CALC drops the op
    start_op("rst_drop", 3'b000, 32'h00012345, 32'h00006789, 32'd0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    rst = 1'b0;
    #1;
    run_op("mul_3x5_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 35);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
